index_to_address_core: RTL and testbench

- Maps a (row, column, matrix-type) triple to a 10-bit word address in the coprocessor's shared matrix memory.
- Memory holds three row-major matrices back to back: A (lambda x gamma), B (gamma x kappa), C (lambda x kappa).
- Sits between the coprocessor controller (which issues indices) and the matrix RAM address port.
- One registered stage: the address is valid one clock after the inputs are sampled.

---
 rtl/index_to_address_core_if.sv | 36 +++
 rtl/index_to_address_core.sv | 125 ++++++++++++
 tb/tb_index_to_address_core.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/index_to_address_core_if.sv
// ============================================================================
// Module      : index_to_address_core_if
// Description : Request/response bundle between the coprocessor controller
//               and the index-to-address translator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface index_to_address_core_if #(
   parameter int ADDR_W = 10,
   parameter int IDX_W  = 8
);
   // Request side: dimension word, indices and matrix select
   logic [31:0]       i_Config;
   logic [IDX_W-1:0]  i_Row_Index;
   logic [IDX_W-1:0]  i_Column_Index;
   logic [2:0]        i_Type;
   // Response side: registered address and status
   logic [ADDR_W-1:0] o_Address;
   logic              o_Valid;
   logic              o_Error;

   // Controller drives the request and observes the result
   modport master (
      output i_Config, i_Row_Index, i_Column_Index, i_Type,
      input  o_Address, o_Valid, o_Error
   );

   // Translator consumes the request and produces the result
   modport slave (
      input  i_Config, i_Row_Index, i_Column_Index, i_Type,
      output o_Address, o_Valid, o_Error
   );
endinterface

`default_nettype wire

// File: rtl/index_to_address_core.sv
// ============================================================================
// Module      : index_to_address_core
// Description : Maps (row, column, matrix type) to a word address in the
//               shared matrix memory holding A, B and C back to back in
//               row-major order. One registered stage, no handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module index_to_address_core #(
   parameter int ADDR_W = 10,
   parameter int IDX_W  = 8
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst,
   index_to_address_core_if.slave bus
);

   // Two products of two IDX_W fields plus one more product and an index
   // need two extra bits beyond 2*IDX_W to never overflow internally.
   localparam int SUM_W = 2 * IDX_W + 2;

   localparam logic [2:0] TYPE_A = 3'b000;
   localparam logic [2:0] TYPE_B = 3'b010;
   localparam logic [2:0] TYPE_C = 3'b100;

   // Dimension fields of the config word
   logic [IDX_W-1:0] lambda;
   logic [IDX_W-1:0] gamma;
   logic [IDX_W-1:0] kappa;
   logic             unused_proc_count;

   assign lambda            = bus.i_Config[0  +: IDX_W];
   assign gamma             = bus.i_Config[8  +: IDX_W];
   assign kappa             = bus.i_Config[24 +: IDX_W];
   // Processor count field is carried in the word but has no role here
   assign unused_proc_count = ^bus.i_Config[23:16];

   // Zero-extended operands at full internal width
   logic [SUM_W-1:0] lambda_x;
   logic [SUM_W-1:0] gamma_x;
   logic [SUM_W-1:0] kappa_x;
   logic [SUM_W-1:0] row_x;
   logic [SUM_W-1:0] col_x;
   logic [SUM_W-1:0] base_b;
   logic [SUM_W-1:0] base_c;

   assign lambda_x = {{(SUM_W-IDX_W){1'b0}}, lambda};
   assign gamma_x  = {{(SUM_W-IDX_W){1'b0}}, gamma};
   assign kappa_x  = {{(SUM_W-IDX_W){1'b0}}, kappa};
   assign row_x    = {{(SUM_W-IDX_W){1'b0}}, bus.i_Row_Index};
   assign col_x    = {{(SUM_W-IDX_W){1'b0}}, bus.i_Column_Index};

   // Bases are recomputed every cycle so a config change applies at once
   assign base_b   = lambda_x * gamma_x;
   assign base_c   = base_b + gamma_x * kappa_x;

   logic [SUM_W-1:0] base;
   logic [SUM_W-1:0] stride;
   logic [IDX_W-1:0] row_lim;
   logic [IDX_W-1:0] col_lim;
   logic             type_ok;

   // Select base, row stride and index limits for the requested matrix
   always_comb begin
      base    = '0;
      stride  = gamma_x;
      row_lim = lambda;
      col_lim = gamma;
      type_ok = 1'b1;
      case (bus.i_Type)
         TYPE_A: begin
            base    = '0;
            stride  = gamma_x;
            row_lim = lambda;
            col_lim = gamma;
         end
         TYPE_B: begin
            base    = base_b;
            stride  = kappa_x;
            row_lim = gamma;
            col_lim = kappa;
         end
         TYPE_C: begin
            base    = base_c;
            stride  = kappa_x;
            row_lim = lambda;
            col_lim = kappa;
         end
         default: begin
            type_ok = 1'b0;
         end
      endcase
   end

   logic [SUM_W-1:0]  sum;
   logic              in_range;
   logic              overflow;
   logic [ADDR_W-1:0] next_address;
   logic              next_error;

   assign sum          = base + row_x * stride + col_x;
   // A zero dimension limit makes every index fail this test
   assign in_range     = (bus.i_Row_Index < row_lim) && (bus.i_Column_Index < col_lim);
   assign overflow     = |sum[SUM_W-1:ADDR_W];
   // Out-of-range requests still expose the wrapped sum; illegal types give 0
   assign next_address = type_ok ? sum[ADDR_W-1:0] : '0;
   assign next_error   = !type_ok || !in_range || overflow;

   // Output register: one-cycle latency, cleared asynchronously by reset
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         bus.o_Address <= '0;
         bus.o_Valid   <= 1'b0;
         bus.o_Error   <= 1'b0;
      end else begin
         bus.o_Address <= next_address;
         bus.o_Valid   <= !next_error;
         bus.o_Error   <= next_error;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_index_to_address_core.sv
// ============================================================================
// Module      : tb_index_to_address_core
// Description : Directed scoreboard bench for index_to_address_core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_index_to_address_core;

   typedef struct packed {
      logic [9:0] addr;
      logic       valid;
      logic       error;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   exp_t  sb_q[$];
   string name_q[$];

   index_to_address_core_if #(.ADDR_W(10), .IDX_W(8)) bus ();

   index_to_address_core #(.ADDR_W(10), .IDX_W(8)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Direct comparison of the outputs against a constant triple
   task automatic check_now(input string nm, input logic [9:0] a, input logic v, input logic e);
      checks++;
      if (bus.o_Address !== a || bus.o_Valid !== v || bus.o_Error !== e) begin
         errors++;
         $display("FAIL %s: got addr=%0d valid=%b error=%b, expected addr=%0d valid=%b error=%b",
                  nm, bus.o_Address, bus.o_Valid, bus.o_Error, a, v, e);
      end
   endtask

   // Drive one request at the falling edge and queue its expected result
   task automatic issue(input string nm, input logic [31:0] cfg, input logic [7:0] r,
                        input logic [7:0] c, input logic [2:0] t,
                        input logic [9:0] a, input logic v, input logic e);
      @(negedge clk);
      bus.i_Config       = cfg;
      bus.i_Row_Index    = r;
      bus.i_Column_Index = c;
      bus.i_Type         = t;
      sb_q.push_back('{addr: a, valid: v, error: e});
      name_q.push_back(nm);
   endtask

   // Monitor: after each rising edge, compare output against the oldest expectation
   initial begin
      exp_t  ex;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            nm = name_q.pop_front();
            check_now(nm, ex.addr, ex.valid, ex.error);
         end
      end
   end

   localparam logic [31:0] CFG8  = 32'h08040808;
   localparam logic [31:0] CFG32 = 32'h20002020;
   localparam logic [31:0] CFGK0 = 32'h00040808;

   initial begin
      bus.i_Config       = CFG8;
      bus.i_Row_Index    = '0;
      bus.i_Column_Index = '0;
      bus.i_Type         = 3'b000;
      #1;
      check_now("reset_initial", 10'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic single requests
      issue("a_0_5",   CFG8, 8'd0, 8'd5, 3'b000, 10'd5,   1'b1, 1'b0);
      issue("b_2_6",   CFG8, 8'd2, 8'd6, 3'b010, 10'd86,  1'b1, 1'b0);
      issue("c_3_7",   CFG8, 8'd3, 8'd7, 3'b100, 10'd159, 1'b1, 1'b0);
      // Back-to-back on consecutive edges, including last legal indices
      issue("a_7_7",   CFG8, 8'd7, 8'd7, 3'b000, 10'd63,  1'b1, 1'b0);
      issue("b_7_7",   CFG8, 8'd7, 8'd7, 3'b010, 10'd127, 1'b1, 1'b0);
      issue("c_7_7",   CFG8, 8'd7, 8'd7, 3'b100, 10'd191, 1'b1, 1'b0);
      issue("c_0_0",   CFG8, 8'd0, 8'd0, 3'b100, 10'd128, 1'b1, 1'b0);
      // Out of range: address still carries the computed sum
      issue("a_row8",  CFG8, 8'd8, 8'd0, 3'b000, 10'd64,  1'b0, 1'b1);
      issue("a_col8",  CFG8, 8'd0, 8'd8, 3'b000, 10'd8,   1'b0, 1'b1);
      issue("b_row8",  CFG8, 8'd8, 8'd0, 3'b010, 10'd128, 1'b0, 1'b1);
      issue("c_col8",  CFG8, 8'd0, 8'd8, 3'b100, 10'd136, 1'b0, 1'b1);
      // Illegal types load address 0
      issue("type001", CFG8, 8'd1, 8'd1, 3'b001, 10'd0,   1'b0, 1'b1);
      issue("type011", CFG8, 8'd1, 8'd1, 3'b011, 10'd0,   1'b0, 1'b1);
      issue("type111", CFG8, 8'd0, 8'd0, 3'b111, 10'd0,   1'b0, 1'b1);
      // Overflow boundary with 32x32 matrices
      issue("c_ovf",   CFG32, 8'd31, 8'd31, 3'b100, 10'd1023, 1'b0, 1'b1);
      issue("a_max",   CFG32, 8'd31, 8'd31, 3'b000, 10'd1023, 1'b1, 1'b0);
      issue("b_ovf",   CFG32, 8'd0,  8'd0,  3'b010, 10'd0,    1'b0, 1'b1);
      issue("a_zero",  CFG32, 8'd0,  8'd0,  3'b000, 10'd0,    1'b1, 1'b0);
      // Zero kappa: B and C unusable, A unaffected
      issue("b_k0",    CFGK0, 8'd0, 8'd0, 3'b010, 10'd64, 1'b0, 1'b1);
      issue("c_k0",    CFGK0, 8'd0, 8'd0, 3'b100, 10'd64, 1'b0, 1'b1);
      issue("a_k0",    CFGK0, 8'd1, 8'd1, 3'b000, 10'd9,  1'b1, 1'b0);
      // Known non-zero state before the mid-stream reset
      issue("pre_rst", CFG8, 8'd0, 8'd5, 3'b000, 10'd5,   1'b1, 1'b0);

      // Mid-stream reset: new request is in flight, then reset between edges
      @(negedge clk);
      bus.i_Config       = CFG8;
      bus.i_Row_Index    = 8'd1;
      bus.i_Column_Index = 8'd2;
      bus.i_Type         = 3'b000;
      #2;
      rst = 1'b1;
      #1;
      check_now("reset_async", 10'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_now("reset_hold", 10'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back('{addr: 10'd10, valid: 1'b1, error: 1'b0});
      name_q.push_back("post_rst");
      issue("post_b",  CFG8, 8'd1, 8'd1, 3'b010, 10'd73, 1'b1, 1'b0);

      // Drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected results still pending, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
